// File: rtl/legv8_multicycle_control_unit.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, MOVK split into
// two register writes, memory handshake with timeout, sticky illegal trap.
//
// state | meaning
// ------+---------------------------------------------------------------
// FETCH | wait for instr_valid, latch instruction into IR
// DECODE| classify opcode, trap on undefined opcode / bad hw field
// EXEC  | ALU op, branch resolution, address generation, MOVK mask
// MEM   | hold mem_rd/mem_wr until mem_ready, bounded by MEM_TO
// WB    | write load data to register file
// MOVK2 | OR shifted imm16 into Rd
// TRAP  | dead state, only reset leaves it
module legv8_multicycle_control_unit #(
   parameter int DATA_W = 64,
   parameter int MEM_TO = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instruction,
   input  logic              instr_valid,
   input  logic [4:0]        status,
   input  logic              mem_ready,
   output logic              ir_load,
   output logic              pc_load,
   output logic [1:0]        pc_sel,
   output logic              rf_we,
   output logic [1:0]        rf_wsel,
   output logic [4:0]        rd_addr,
   output logic              alu_b_sel,
   output logic [3:0]        alu_fs,
   output logic              flag_we,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] constant,
   output logic [2:0]        state,
   output logic              illegal
);

   localparam int CW = (MEM_TO < 2) ? 1 : $clog2(MEM_TO);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
      S_WB = 3'd4, S_MOVK2 = 3'd5, S_TRAP = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      C_UND, C_RALU, C_IALU, C_SHIFT, C_LDUR, C_STUR, C_MOVZ, C_MOVK,
      C_CBZ, C_CBNZ, C_BCOND, C_B, C_BL, C_BR
   } cls_t;

   state_t        state_q, state_d;
   logic [31:0]   ir_q, ir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          illegal_q, illegal_d;

   cls_t          cls;
   logic [3:0]    fs;
   logic          set_fl;
   logic          bad_hw;
   logic          cond_ok;
   logic [5:0]    sh_amt;

   // State, IR, timeout counter and sticky illegal flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Opcode classification from IR[31:21]
   always_comb begin
      cls    = C_UND;
      fs     = 4'd0;
      set_fl = 1'b0;
      casez (ir_q[31:21])
         11'b10001011000: begin cls = C_RALU; fs = 4'd0; end
         11'b11001011000: begin cls = C_RALU; fs = 4'd1; end
         11'b10001010000: begin cls = C_RALU; fs = 4'd2; end
         11'b10101010000: begin cls = C_RALU; fs = 4'd3; end
         11'b11001010000: begin cls = C_RALU; fs = 4'd4; end
         11'b10101011000: begin cls = C_RALU; fs = 4'd0; set_fl = 1'b1; end
         11'b11101011000: begin cls = C_RALU; fs = 4'd1; set_fl = 1'b1; end
         11'b11101010000: begin cls = C_RALU; fs = 4'd2; set_fl = 1'b1; end
         11'b11010011011: begin cls = C_SHIFT; fs = 4'd5; end
         11'b11010011010: begin cls = C_SHIFT; fs = 4'd6; end
         11'b11010110000: cls = C_BR;
         11'b1001000100?: begin cls = C_IALU; fs = 4'd0; end
         11'b1101000100?: begin cls = C_IALU; fs = 4'd1; end
         11'b1001001000?: begin cls = C_IALU; fs = 4'd2; end
         11'b1011001000?: begin cls = C_IALU; fs = 4'd3; end
         11'b1101001000?: begin cls = C_IALU; fs = 4'd4; end
         11'b1011000100?: begin cls = C_IALU; fs = 4'd0; set_fl = 1'b1; end
         11'b1111000100?: begin cls = C_IALU; fs = 4'd1; set_fl = 1'b1; end
         11'b1111001000?: begin cls = C_IALU; fs = 4'd2; set_fl = 1'b1; end
         11'b11111000010: cls = C_LDUR;
         11'b11111000000: cls = C_STUR;
         11'b110100101??: cls = C_MOVZ;
         11'b111100101??: cls = C_MOVK;
         11'b10110100???: cls = C_CBZ;
         11'b10110101???: cls = C_CBNZ;
         11'b01010100???: cls = C_BCOND;
         11'b000101?????: cls = C_B;
         11'b100101?????: cls = C_BL;
         default:         cls = C_UND;
      endcase
   end

   // Wide-move hw field check and B.cond evaluation on {N,Z,C,V}
   always_comb begin
      sh_amt = {ir_q[22:21], 4'b0000};
      bad_hw = ((cls == C_MOVZ) || (cls == C_MOVK)) && ((int'(ir_q[22:21]) * 16) >= DATA_W);
      case (ir_q[3:0])
         4'h0:    cond_ok = status[2];
         4'h1:    cond_ok = !status[2];
         4'h2:    cond_ok = status[1];
         4'h3:    cond_ok = !status[1];
         4'h4:    cond_ok = status[3];
         4'h5:    cond_ok = !status[3];
         4'h6:    cond_ok = status[0];
         4'h7:    cond_ok = !status[0];
         4'h8:    cond_ok = status[1] && !status[2];
         4'h9:    cond_ok = !(status[1] && !status[2]);
         4'hA:    cond_ok = (status[3] == status[0]);
         4'hB:    cond_ok = (status[3] != status[0]);
         4'hC:    cond_ok = !status[2] && (status[3] == status[0]);
         4'hD:    cond_ok = !(!status[2] && (status[3] == status[0]));
         default: cond_ok = 1'b1;
      endcase
   end

   // Immediate generation; MOVK carries the clear mask in EXEC and the value in MOVK2
   always_comb begin
      constant = '0;
      case (cls)
         C_IALU:                 constant = {{(DATA_W-12){1'b0}}, ir_q[21:10]};
         C_LDUR, C_STUR:         constant = {{(DATA_W-9){ir_q[20]}}, ir_q[20:12]};
         C_CBZ, C_CBNZ, C_BCOND: constant = {{(DATA_W-19){ir_q[23]}}, ir_q[23:5]};
         C_B, C_BL:              constant = {{(DATA_W-26){ir_q[25]}}, ir_q[25:0]};
         C_SHIFT:                constant = {{(DATA_W-6){1'b0}}, ir_q[15:10]};
         C_MOVZ:                 constant = {{(DATA_W-16){1'b0}}, ir_q[20:5]} << sh_amt;
         C_MOVK: begin
            if (state_q == S_MOVK2)
               constant = {{(DATA_W-16){1'b0}}, ir_q[20:5]} << sh_amt;
            else
               constant = ~({{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_amt);
         end
         default:                constant = '0;
      endcase
   end

   // Next-state and control outputs
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      cnt_d     = '0;
      illegal_d = illegal_q;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_sel    = 2'd0;
      rf_we     = 1'b0;
      rf_wsel   = 2'd0;
      rd_addr   = (cls == C_BL) ? 5'd30 : ir_q[4:0];
      alu_b_sel = 1'b0;
      alu_fs    = 4'd0;
      flag_we   = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      case (state_q)
         S_FETCH: begin
            // gate with reset so every control output is quiet while reset is held
            ir_load = instr_valid && !reset;
            if (instr_valid) begin
               ir_d    = instruction;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if ((cls == C_UND) || bad_hw) begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (cls)
               C_RALU: begin
                  alu_fs = fs; rf_we = 1'b1; pc_load = 1'b1; flag_we = set_fl;
               end
               C_IALU: begin
                  alu_fs = fs; alu_b_sel = 1'b1; rf_we = 1'b1; pc_load = 1'b1; flag_we = set_fl;
               end
               C_SHIFT: begin
                  alu_fs = fs; alu_b_sel = 1'b1; rf_we = 1'b1; pc_load = 1'b1;
               end
               C_LDUR, C_STUR: begin
                  alu_fs = 4'd0; alu_b_sel = 1'b1; state_d = S_MEM;
               end
               C_MOVZ: begin
                  alu_fs = 4'd7; alu_b_sel = 1'b1; rf_we = 1'b1; pc_load = 1'b1;
               end
               C_MOVK: begin
                  alu_fs = 4'd2; alu_b_sel = 1'b1; rf_we = 1'b1; state_d = S_MOVK2;
               end
               C_CBZ: begin
                  alu_fs = 4'd7; pc_load = 1'b1; pc_sel = status[4] ? 2'd1 : 2'd0;
               end
               C_CBNZ: begin
                  alu_fs = 4'd7; pc_load = 1'b1; pc_sel = status[4] ? 2'd0 : 2'd1;
               end
               C_BCOND: begin
                  pc_load = 1'b1; pc_sel = cond_ok ? 2'd1 : 2'd0;
               end
               C_B: begin
                  pc_load = 1'b1; pc_sel = 2'd1;
               end
               C_BL: begin
                  pc_load = 1'b1; pc_sel = 2'd1; rf_we = 1'b1; rf_wsel = 2'd2;
               end
               C_BR: begin
                  pc_load = 1'b1; pc_sel = 2'd2;
               end
               default: state_d = S_TRAP;
            endcase
         end
         S_MEM: begin
            alu_fs    = 4'd0;
            alu_b_sel = 1'b1;
            mem_rd    = (cls == C_LDUR);
            mem_wr    = (cls == C_STUR);
            if (mem_ready) begin
               if (cls == C_LDUR) begin
                  state_d = S_WB;
               end else begin
                  pc_load = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (MEM_TO != 0) begin
               if (cnt_q == CW'(MEM_TO - 1)) begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_WB: begin
            rf_we = 1'b1; rf_wsel = 2'd1; pc_load = 1'b1; state_d = S_FETCH;
         end
         S_MOVK2: begin
            rf_we = 1'b1; alu_fs = 4'd3; alu_b_sel = 1'b1; pc_load = 1'b1; state_d = S_FETCH;
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   assign state   = state_q;
   assign illegal = illegal_q;

endmodule
